// File: rtl/key_pkg.sv
// Shared types and constants for the push-button conditioning front end.
// Keys are active-low at the pins and active-high everywhere downstream.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } key_state_t;

  localparam int DEBOUNCE_DEFAULT = 1000000;
  localparam int DEBOUNCE_SIM     = 4;

endpackage

// File: rtl/debounce_channel.sv
// One key: two-flop synchroniser, stability counter, FSM and strobes.
// A level change is accepted after DEBOUNCE_CYCLES identical samples.
module debounce_channel
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic level,
  output logic press,
  output logic rel,
  output logic press_nxt
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync;
  logic             s;
  key_state_t       state;
  key_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             at_last;
  logic             level_nxt;
  logic             rel_nxt;

  // Idles high so a reset looks like a released key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], key_raw};
    end
  end

  assign s       = ~sync[1];
  assign at_last = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    unique case (state)
      IDLE: begin
        if (s) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = CNT_W'(1);
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_nxt = IDLE;
        end else if (at_last) begin
          state_nxt = PRESSED;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!s) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = CNT_W'(1);
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_nxt = PRESSED;
        end else if (at_last) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
    endcase
  end

  always_comb begin
    level_nxt = (state_nxt == PRESSED) ||
                (state_nxt == RELEASE_WAIT);
    press_nxt = (state == PRESS_WAIT) &&
                (state_nxt == PRESSED);
    rel_nxt   = (state == RELEASE_WAIT) &&
                (state_nxt == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      level <= level_nxt;
      press <= press_nxt;
      rel   <= rel_nxt;
    end
  end

endmodule

// File: rtl/key_conditioner.sv
// Board key front end: NUM_KEYS independent debounce channels
// plus a registered any-press strobe for single-step control.
module key_conditioner
  import key_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic                CLOCK_50,
  input  logic                RESET_N,
  input  logic [NUM_KEYS-1:0] KEY,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                any_press
);

  logic [NUM_KEYS-1:0] press_nxt;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk      (CLOCK_50),
      .rst_n    (RESET_N),
      .key_raw  (KEY[i]),
      .level    (key_level[i]),
      .press    (key_press[i]),
      .rel      (key_release[i]),
      .press_nxt(press_nxt[i])
    );
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      any_press <= 1'b0;
    end else begin
      any_press <= |press_nxt;
    end
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: directed scenarios plus random bouncing
// keys compared against a run-length reference model.
module tb_key_conditioner;
  import key_pkg::*;

  localparam int D = DEBOUNCE_SIM;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] key;
  logic [N-1:0] key_level;
  logic [N-1:0] key_press;
  logic [N-1:0] key_release;
  logic         any_press;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  key_conditioner #(
    .NUM_KEYS       (N),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .CLOCK_50   (clk),
    .RESET_N    (rst_n),
    .KEY        (key),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .any_press  (any_press)
  );

  // Model: raw keys seen two clocks late; a level flips once
  // D consecutive samples disagree with it.
  logic [N-1:0] hist[$];
  int           run[N];
  logic [N-1:0] m_level;
  logic [N-1:0] m_press;
  logic [N-1:0] m_rel;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist = {4'hF, 4'hF, 4'hF};
    for (int i = 0; i < N; i++) run[i] = 0;
    m_level = '0;
    m_press = '0;
    m_rel   = '0;
  endtask

  task automatic model_edge();
    logic [N-1:0] s;
    hist.push_back(key);
    void'(hist.pop_front());
    s = ~hist[0];
    m_press = '0;
    m_rel   = '0;
    for (int i = 0; i < N; i++) begin
      if (s[i] != m_level[i]) begin
        run[i]++;
        if (run[i] == D) begin
          m_level[i] = s[i];
          m_press[i] = s[i];
          m_rel[i]   = ~s[i];
          run[i]     = 0;
        end
      end else begin
        run[i] = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    #1;
    check("level", 32'(key_level), 32'(m_level));
    check("press", 32'(key_press), 32'(m_press));
    check("release", 32'(key_release), 32'(m_rel));
    check("any", 32'(any_press), 32'(|m_press));
    check("excl", 32'(key_press & key_release), 32'd0);
  endtask

  task automatic watch(input int n, input int ch, input bit rls,
                       output int first, output int cnt);
    logic hit;
    first = -1;
    cnt   = 0;
    for (int k = 1; k <= n; k++) begin
      tick();
      hit = rls ? key_release[ch] : key_press[ch];
      if (hit) begin
        cnt++;
        if (first < 0) first = k;
      end
    end
  endtask

  task automatic hold(input int n, input int ch, input logic v);
    for (int k = 0; k < n; k++) begin
      key[ch] = v;
      tick();
    end
  endtask

  int first;
  int cnt;
  int strobes;
  int any_at;
  logic [N-1:0] seen;
  int hold_left[N];

  initial begin
    model_reset();
    rst_n = 1'b0;
    key   = 4'b0000;
    #2;
    check("rst_level", 32'(key_level), 32'd0);
    check("rst_press", 32'(key_press), 32'd0);
    check("rst_rel", 32'(key_release), 32'd0);
    check("rst_any", 32'(any_press), 32'd0);
    for (int k = 0; k < 3; k++) tick();
    rst_n = 1'b1;
    key   = 4'hF;
    strobes = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      strobes += $countones({key_press, key_release});
    end
    check("idle_strobes", 32'(strobes), 32'd0);

    // clean press and release on key 0
    key[0] = 1'b0;
    first  = -1;
    any_at = -1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (key_press[0] && first < 0) first = k;
      if (any_press && any_at < 0) any_at = k;
    end
    check("press_lat", 32'(first), 32'd6);
    check("any_lat", 32'(any_at), 32'd6);
    check("press_level", 32'(key_level[0]), 32'd1);
    key[0] = 1'b1;
    watch(12, 0, 1'b1, first, cnt);
    check("rel_lat", 32'(first), 32'd6);
    check("rel_cnt", 32'(cnt), 32'd1);
    check("rel_level", 32'(key_level[0]), 32'd0);

    // bouncing key 1
    strobes = 0;
    hold(2, 1, 1'b0);
    strobes += key_press[1];
    hold(1, 1, 1'b1);
    strobes += key_press[1];
    hold(3, 1, 1'b0);
    strobes += key_press[1];
    key[1] = 1'b1;
    watch(8, 1, 1'b0, first, cnt);
    check("bounce_none", 32'(cnt + strobes), 32'd0);
    key[1] = 1'b0;
    watch(15, 1, 1'b0, first, cnt);
    check("bounce_lat", 32'(first), 32'd6);
    check("bounce_cnt", 32'(cnt), 32'd1);
    key[1] = 1'b1;
    for (int k = 0; k < 12; k++) tick();

    // simultaneous keys 3 and 2
    key[3:2] = 2'b00;
    seen = '0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (key_press != '0 && seen == '0) seen = key_press;
    end
    check("simul", 32'(seen), 32'hC);
    strobes = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      strobes += $countones(key_press);
    end
    check("no_repeat", 32'(strobes), 32'd0);
    check("hold_level", 32'(key_level), 32'hC);
    key = 4'hF;
    for (int k = 0; k < 12; k++) tick();

    // reset in the middle of a debounce
    key[0] = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst", 32'({key_level, key_press, key_release, any_press}), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    watch(12, 0, 1'b0, first, cnt);
    check("post_rst_lat", 32'(first), 32'd6);
    check("post_rst_cnt", 32'(cnt), 32'd1);
    key[0] = 1'b1;
    for (int k = 0; k < 12; k++) tick();

    // glitch one sample short of the threshold
    hold(D - 1, 2, 1'b0);
    key[2] = 1'b1;
    watch(12, 2, 1'b0, first, cnt);
    check("near_thr", 32'(cnt), 32'd0);
    check("near_level", 32'(key_level[2]), 32'd0);

    // random bouncing on every key
    for (int i = 0; i < N; i++) hold_left[i] = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (hold_left[i] == 0) begin
          key[i] = ~key[i];
          hold_left[i] = $urandom_range(1, 9);
        end
        hold_left[i]--;
      end
      rst_n = ($urandom_range(0, 599) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
